// File: rtl/mesi_snoop_responder_if.sv
// Bus-side signal bundle for the MESI snoop responder: local update port,
// snoop request/response, writeback handshake and line observation.
interface mesi_snoop_responder_if #(
   parameter int ADDR_W  = 32,
   parameter int INDEX_W = 2
);
   // valid/ready pairs: a transfer happens on a rising edge where both are 1;
   // the source holds its payload stable while valid is high and not yet accepted.
   logic               loc_upd_valid;
   logic               loc_upd_ready;
   logic [ADDR_W-1:0]  loc_upd_addr;
   logic [1:0]         loc_upd_state;
   logic               snp_valid;
   logic               snp_ready;
   logic [1:0]         snp_op;
   logic [ADDR_W-1:0]  snp_addr;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [1:0]         rsp_result;
   logic               wb_valid;
   logic [ADDR_W-1:0]  wb_addr;
   logic               wb_ack;
   logic [INDEX_W-1:0] dbg_index;
   logic [1:0]         dbg_state;
   logic [1:0]         dbg_fsm;

   modport slave (
      input  loc_upd_valid, loc_upd_addr, loc_upd_state,
      input  snp_valid, snp_op, snp_addr, rsp_ready, wb_ack, dbg_index,
      output loc_upd_ready, snp_ready, rsp_valid, rsp_result,
      output wb_valid, wb_addr, dbg_state, dbg_fsm
   );

   modport master (
      output loc_upd_valid, loc_upd_addr, loc_upd_state,
      output snp_valid, snp_op, snp_addr, rsp_ready, wb_ack, dbg_index,
      input  loc_upd_ready, snp_ready, rsp_valid, rsp_result,
      input  wb_valid, wb_addr, dbg_state, dbg_fsm
   );
endinterface

// File: rtl/mesi_snoop_responder.sv
// Snoop responder for a small direct-mapped set of MESI lines: answers bus
// snoops with NOHIT/HIT/HITM, writing back Modified lines before responding.
module mesi_snoop_responder #(
   parameter int ADDR_W   = 32,
   parameter int INDEX_W  = 2,
   parameter int OFFSET_W = 6
) (
   input  logic                   clk,
   input  logic                   reset,
   mesi_snoop_responder_if.slave  bus
);
   localparam int LINES = 1 << INDEX_W;
   localparam int TAG_W = ADDR_W - OFFSET_W - INDEX_W;

   localparam logic [1:0] MESI_I    = 2'b00;
   localparam logic [1:0] MESI_S    = 2'b01;
   localparam logic [1:0] MESI_M    = 2'b11;
   localparam logic [1:0] OP_READ   = 2'b00;
   localparam logic [1:0] RES_NOHIT = 2'b00;
   localparam logic [1:0] RES_HIT   = 2'b01;
   localparam logic [1:0] RES_HITM  = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LOOKUP    = 2'd1,
      ST_WRITEBACK = 2'd2,
      ST_RESPOND   = 2'd3
   } fsm_t;

   fsm_t               state_q, state_d;
   logic [1:0]         op_q, op_d;
   logic [INDEX_W-1:0] idx_q, idx_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic [1:0]         result_q, result_d;
   logic [1:0]         pend_q, pend_d;
   logic [TAG_W-1:0]   line_tag_q [LINES];
   logic [TAG_W-1:0]   line_tag_d [LINES];
   logic [1:0]         line_st_q  [LINES];
   logic [1:0]         line_st_d  [LINES];

   logic [INDEX_W-1:0] upd_idx, snp_idx;
   logic [TAG_W-1:0]   upd_tag, snp_tag;
   logic               upd_block, upd_fire, hit;
   logic [1:0]         snoop_new_st;

   assign upd_idx = bus.loc_upd_addr[OFFSET_W +: INDEX_W];
   assign upd_tag = bus.loc_upd_addr[ADDR_W-1 -: TAG_W];
   assign snp_idx = bus.snp_addr[OFFSET_W +: INDEX_W];
   assign snp_tag = bus.snp_addr[ADDR_W-1 -: TAG_W];

   // The snoop owns its captured line from LOOKUP until its update lands.
   assign upd_block = ((state_q == ST_LOOKUP) || (state_q == ST_WRITEBACK))
                      && (upd_idx == idx_q);
   assign upd_fire  = bus.loc_upd_valid && !upd_block;

   assign hit          = (line_tag_q[idx_q] == tag_q) && (line_st_q[idx_q] != MESI_I);
   assign snoop_new_st = (op_q == OP_READ) ? MESI_S : MESI_I;

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      idx_d      = idx_q;
      tag_d      = tag_q;
      result_d   = result_q;
      pend_d     = pend_q;
      line_tag_d = line_tag_q;
      line_st_d  = line_st_q;

      if (upd_fire) begin
         line_tag_d[upd_idx] = upd_tag;
         line_st_d[upd_idx]  = bus.loc_upd_state;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (bus.snp_valid) begin
               op_d    = bus.snp_op;
               idx_d   = snp_idx;
               tag_d   = snp_tag;
               state_d = ST_LOOKUP;
            end
         end
         ST_LOOKUP: begin
            if (!hit) begin
               result_d = RES_NOHIT;
               state_d  = ST_RESPOND;
            end else if (line_st_q[idx_q] == MESI_M) begin
               result_d = RES_HITM;
               pend_d   = snoop_new_st;
               state_d  = ST_WRITEBACK;
            end else begin
               result_d         = RES_HIT;
               line_st_d[idx_q] = snoop_new_st;
               state_d          = ST_RESPOND;
            end
         end
         ST_WRITEBACK: begin
            if (bus.wb_ack) begin
               line_st_d[idx_q] = pend_q;
               state_d          = ST_RESPOND;
            end
         end
         ST_RESPOND: begin
            if (bus.rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         op_q     <= '0;
         idx_q    <= '0;
         tag_q    <= '0;
         result_q <= RES_NOHIT;
         pend_q   <= MESI_I;
         for (int i = 0; i < LINES; i++) begin
            line_tag_q[i] <= '0;
            line_st_q[i]  <= MESI_I;
         end
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         idx_q      <= idx_d;
         tag_q      <= tag_d;
         result_q   <= result_d;
         pend_q     <= pend_d;
         line_tag_q <= line_tag_d;
         line_st_q  <= line_st_d;
      end
   end

   assign bus.snp_ready     = (state_q == ST_IDLE);
   assign bus.loc_upd_ready = !upd_block;
   assign bus.rsp_valid     = (state_q == ST_RESPOND);
   assign bus.rsp_result    = result_q;
   assign bus.wb_valid      = (state_q == ST_WRITEBACK);
   assign bus.wb_addr       = bus.wb_valid ? {tag_q, idx_q, {OFFSET_W{1'b0}}} : '0;
   assign bus.dbg_state     = line_st_q[bus.dbg_index];
   assign bus.dbg_fsm       = state_q;
endmodule

// File: tb/tb_mesi_snoop_responder.sv
// Directed bench for mesi_snoop_responder: snoop responses are scored through
// an expected queue drained by a monitor on the response handshake.
module tb_mesi_snoop_responder;
   localparam int ADDR_W  = 32;
   localparam int INDEX_W = 2;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   logic [1:0] exp_q[$];

   mesi_snoop_responder_if #(.ADDR_W(ADDR_W), .INDEX_W(INDEX_W)) bus ();

   mesi_snoop_responder #(.ADDR_W(ADDR_W), .INDEX_W(INDEX_W), .OFFSET_W(6)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: ready never seen within cycle budget", name);
   endtask

   task automatic check_dbg(input int idx, input logic [1:0] exp, input string name);
      bus.dbg_index = idx[INDEX_W-1:0];
      #1;
      check(name, {30'd0, bus.dbg_state}, {30'd0, exp});
   endtask

   // driver tasks: called at posedge+1, return at posedge+1 after the handshake
   task automatic loc_upd(input logic [31:0] addr, input logic [1:0] st);
      int n;
      bus.loc_upd_valid = 1'b1;
      bus.loc_upd_addr  = addr;
      bus.loc_upd_state = st;
      n = 0;
      while (!bus.loc_upd_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      if (!bus.loc_upd_ready) timeout("loc_upd_ready");
      @(posedge clk); #1;
      bus.loc_upd_valid = 1'b0;
   endtask

   task automatic snoop(input logic [1:0] op, input logic [31:0] addr,
                        input logic push, input logic [1:0] exp);
      int n;
      bus.snp_valid = 1'b1;
      bus.snp_op    = op;
      bus.snp_addr  = addr;
      n = 0;
      while (!bus.snp_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      if (!bus.snp_ready) timeout("snp_ready");
      if (push) exp_q.push_back(exp);
      @(posedge clk); #1;
      bus.snp_valid = 1'b0;
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (reset && bus.rsp_valid && bus.rsp_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected: got result 0x%0h, expected no response", bus.rsp_result);
         end else begin
            logic [1:0] e;
            e = exp_q.pop_front();
            if (bus.rsp_result !== e) begin
               errors++;
               $display("FAIL rsp_result: got 0x%0h, expected 0x%0h", bus.rsp_result, e);
            end
         end
      end
   end

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      bus.loc_upd_valid = 1'b0;
      bus.loc_upd_addr  = '0;
      bus.loc_upd_state = 2'b00;
      bus.snp_valid     = 1'b0;
      bus.snp_op        = 2'b00;
      bus.snp_addr      = '0;
      bus.rsp_ready     = 1'b1;
      bus.wb_ack        = 1'b0;
      bus.dbg_index     = '0;
      #12;
      check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      check("rst_rsp_result", {30'd0, bus.rsp_result}, 32'd0);
      check("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
      check("rst_wb_addr", bus.wb_addr, 32'd0);
      check("rst_snp_ready", {31'd0, bus.snp_ready}, 32'd1);
      check("rst_upd_ready", {31'd0, bus.loc_upd_ready}, 32'd1);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;

      // miss on an empty cache
      snoop(2'b00, 32'h0000_1000, 1'b1, 2'b00);
      check("s1_lookup_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
      check("s1_snp_ready_busy", {31'd0, bus.snp_ready}, 32'd0);
      @(posedge clk); #1;
      check("s1_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) check_dbg(i, 2'b00, "s1_all_inv");
      @(posedge clk); #1;

      // E line read hit downgrades to S
      loc_upd(32'h0000_1040, 2'b10);
      check_dbg(1, 2'b10, "s2_installed_e");
      snoop(2'b00, 32'h0000_1040, 1'b1, 2'b01);
      check("s2_no_wb_lookup", {31'd0, bus.wb_valid}, 32'd0);
      @(posedge clk); #1;
      check("s2_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      check("s2_no_wb", {31'd0, bus.wb_valid}, 32'd0);
      check_dbg(1, 2'b01, "s2_line1_s");
      @(posedge clk); #1;

      // M line RWIM: writeback with stalled ack, concurrent updates
      loc_upd(32'h0000_2080, 2'b11);
      snoop(2'b10, 32'h0000_2080, 1'b1, 2'b10);
      @(posedge clk); #1;
      check("s3_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
      check("s3_wb_addr", bus.wb_addr, 32'h0000_2080);
      check("s3_fsm_wb", {30'd0, bus.dbg_fsm}, 32'd2);
      bus.loc_upd_valid = 1'b1;
      bus.loc_upd_addr  = 32'h0000_30C0;
      bus.loc_upd_state = 2'b10;
      #1;
      check("s3_idx3_ready", {31'd0, bus.loc_upd_ready}, 32'd1);
      @(posedge clk); #1;
      bus.loc_upd_addr  = 32'h0000_5080;
      bus.loc_upd_state = 2'b01;
      for (int c = 0; c < 3; c++) begin
         #1;
         check("s3_idx2_blocked", {31'd0, bus.loc_upd_ready}, 32'd0);
         check("s3_wb_hold", {31'd0, bus.wb_valid}, 32'd1);
         check("s3_wb_addr_hold", bus.wb_addr, 32'h0000_2080);
         check("s3_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
         @(posedge clk); #1;
      end
      bus.wb_ack = 1'b1;
      @(posedge clk); #1;
      bus.wb_ack = 1'b0;
      check("s3_rsp_after_ack", {31'd0, bus.rsp_valid}, 32'd1);
      check("s3_wb_dropped", {31'd0, bus.wb_valid}, 32'd0);
      check("s3_idx2_released", {31'd0, bus.loc_upd_ready}, 32'd1);
      check_dbg(2, 2'b00, "s3_line2_inv");
      check_dbg(3, 2'b10, "s3_line3_e");
      @(posedge clk); #1;
      bus.loc_upd_valid = 1'b0;
      check_dbg(2, 2'b01, "s3_line2_reinstalled");

      // WRITE hit on E line invalidates without writeback
      snoop(2'b01, 32'h0000_30C0, 1'b1, 2'b01);
      @(posedge clk); #1;
      check("s4_no_wb", {31'd0, bus.wb_valid}, 32'd0);
      @(posedge clk); #1;
      check_dbg(3, 2'b00, "s4_line3_inv");

      // tag mismatch INVALIDATE with stalled response
      bus.rsp_ready = 1'b0;
      snoop(2'b11, 32'h0000_3040, 1'b1, 2'b00);
      @(posedge clk); #1;
      for (int c = 0; c < 4; c++) begin
         check("s5_rsp_hold", {31'd0, bus.rsp_valid}, 32'd1);
         check("s5_result_hold", {30'd0, bus.rsp_result}, 32'd0);
         check("s5_snp_busy", {31'd0, bus.snp_ready}, 32'd0);
         @(posedge clk); #1;
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      check("s5_rsp_done", {31'd0, bus.rsp_valid}, 32'd0);
      check("s5_snp_ready", {31'd0, bus.snp_ready}, 32'd1);
      check_dbg(1, 2'b01, "s5_line1_still_s");

      // reset during writeback aborts the snoop
      loc_upd(32'h0000_4000, 2'b11);
      snoop(2'b00, 32'h0000_4000, 1'b0, 2'b00);
      @(posedge clk); #1;
      check("s6_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
      #1;
      reset = 1'b0;
      #1;
      check("s6_wb_cleared", {31'd0, bus.wb_valid}, 32'd0);
      check("s6_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
      for (int i = 0; i < 4; i++) check_dbg(i, 2'b00, "s6_all_inv");
      @(posedge clk); #1;
      reset = 1'b1;
      bus.wb_ack = 1'b1;
      @(posedge clk); #1;
      bus.wb_ack = 1'b0;
      for (int c = 0; c < 3; c++) begin
         check("s6_snp_ready", {31'd0, bus.snp_ready}, 32'd1);
         check("s6_idle_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
         @(posedge clk); #1;
      end

      check("exp_q_drained", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mesi_snoop_responder.md
Name: mesi_snoop_responder

Overview:
- Bus-side counterpart of the per-line MESI processor-side FSM.
- Holds MESI state and tag for a small direct-mapped set of cache lines.
- Answers snoops from other bus agents with NOHIT/HIT/HITM and downgrades or invalidates the line.
- For Modified lines, issues a writeback handshake before responding. The local processor side installs and updates lines through a separate update port.

Parameters:
ADDR_W, 32, snoop/line address width
INDEX_W, 2, line index bits (2^INDEX_W lines)
OFFSET_W, 6, byte-offset bits within a line

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
loc_upd_valid  in  1  local line install/update request
loc_upd_ready  out  1  update accepted when valid&ready
loc_upd_addr  in  ADDR_W  line address of update
loc_upd_state  in  2  new MESI state (I=00, S=01, E=10, M=11)
snp_valid  in  1  snoop request valid
snp_ready  out  1  snoop accepted when valid&ready
snp_op  in  2  00 READ, 01 WRITE, 10 RWIM, 11 INVALIDATE
snp_addr  in  ADDR_W  snooped address
rsp_valid  out  1  snoop result valid
rsp_ready  in  1  result consumed when valid&ready
rsp_result  out  2  00 NOHIT, 01 HIT, 10 HITM
wb_valid  out  1  writeback request for Modified line
wb_addr  out  ADDR_W  line-aligned writeback address
wb_ack  in  1  writeback complete
dbg_index  in  INDEX_W  line select for observation
dbg_state  out  2  MESI state of line dbg_index (combinational)

Behaviour:
- Address split:
  - index = addr[OFFSET_W +: INDEX_W]
  - tag = addr[ADDR_W-1 : OFFSET_W+INDEX_W]
- Reset (reset=0, async):
  - All line states I, all tags 0, FSM IDLE.
  - rsp_valid=0, rsp_result=00, wb_valid=0, wb_addr=0.
  - snp_ready=1, loc_upd_ready=1.
  - Reset mid-operation aborts the snoop: no response, no line update.
- FSM states:
  - IDLE:
    - snp_ready=1.
    - On snp_valid, capture op, index and tag, then go to LOOKUP.
  - LOOKUP (exactly 1 cycle):
    - hit = (tag match) && (state != I).
    - Miss: result NOHIT, line unchanged, go to RESPOND.
    - READ hit:
      - S -> S, HIT
      - E -> S, HIT
      - M -> S, HITM, via WRITEBACK
    - WRITE, RWIM or INVALIDATE hit:
      - S or E -> I, HIT
      - M -> I, HITM, via WRITEBACK
    - Non-HITM line update is written at the LOOKUP clock edge.
  - WRITEBACK:
    - wb_valid=1, wb_addr={captured tag, index, OFFSET_W'b0}, both held stable.
    - On wb_ack: apply the line update, drop wb_valid the next cycle, go to RESPOND.
    - wb_ack outside WRITEBACK is ignored.
  - RESPOND:
    - rsp_valid=1, rsp_result held stable.
    - On rsp_ready, go to IDLE.
- snp_ready=0 in every state except IDLE.
- Latency:
  - Handshake at edge T gives rsp_valid at cycle T+2 with no writeback.
  - With a writeback, rsp_valid comes 1 cycle after the wb_ack cycle.
  - Maximum rate is one snoop per 3 cycles.
- Local updates:
  - Each accepted update writes tag and state of the line at its index in one cycle.
  - loc_upd_state=I invalidates that line.
  - loc_upd_ready=0 only while the FSM is in LOOKUP or WRITEBACK and the update index equals the captured snoop index. This rules out same-cycle conflicting writes.
  - Updates to other indices proceed concurrently.
- An update accepted in the IDLE cycle of a snoop handshake to the same index is visible to that snoop's LOOKUP.

Test Plan:
- Reset, snoop READ 0x0000_1000 -> rsp_result=NOHIT at T+2, all dbg_state=I.
- loc_upd E @0x0000_1040, then snoop READ 0x0000_1040 -> HIT at T+2, dbg_state[1]=S, no wb_valid.
- loc_upd M @0x0000_2080, snoop RWIM 0x0000_2080 -> wb_valid=1, wb_addr=0x0000_2080; hold wb_ack=0 three cycles, then 1 -> HITM next cycle, dbg_state[2]=I.
- Line 1 S with tag of 0x1040, snoop INVALIDATE 0x0000_3040 -> NOHIT, dbg_state[1] stays S; hold rsp_ready=0 four cycles -> rsp_valid/rsp_result stable, snp_ready=0 throughout.
- During the WRITEBACK of the third scenario, loc_upd index 2 -> loc_upd_ready=0 until after wb_ack; loc_upd index 3 in the same window -> accepted immediately.
- Assert reset=0 mid-WRITEBACK -> wb_valid=0 immediately, all lines I, no response issued, snp_ready=1 after release.
